key_step_counter: RTL

//  Parametrised front-panel input block: synchronises and debounces NUM_KEYS active-low push buttons.

---
 rtl/key_step_counter_pkg.sv | 17 +
 rtl/key_step_counter_if.sv | 28 ++
 rtl/key_step_counter_debounce.sv | 123 ++++++++++++
 rtl/key_step_counter.sv | 97 +++++++++
 4 files changed

// File: rtl/key_step_counter_pkg.sv
// Shared types and constants for the key_step_counter front-panel block.
//   key_state_t : per-key debounce FSM state
//   INC_KEY     : key index that steps the index up
//   DEC_KEY     : key index that steps the index down
package key_step_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_t;

  localparam int INC_KEY = 0;
  localparam int DEC_KEY = 1;

endpackage

// File: rtl/key_step_counter_if.sv
// Push-button / index bundle between the panel block and its user.
//   KEY_N       : raw active-low buttons (driven by master)
//   key_pressed : one-cycle press / repeat pulses
//   key_held    : debounced held level
//   index       : bounded selector index
//   index_wrap  : one-cycle pulse when the index wrapped
// master = the side that owns the buttons and consumes the index,
// slave  = key_step_counter itself.
interface key_step_counter_if #(
  parameter int NUM_KEYS = 4,
  parameter int IDX_W    = 5
);
  logic [NUM_KEYS-1:0] KEY_N;
  logic [NUM_KEYS-1:0] key_pressed;
  logic [NUM_KEYS-1:0] key_held;
  logic [IDX_W-1:0]    index;
  logic                index_wrap;

  modport master (
    output KEY_N,
    input  key_pressed, key_held, index, index_wrap
  );

  modport slave (
    input  KEY_N,
    output key_pressed, key_held, index, index_wrap
  );
endinterface

// File: rtl/key_step_counter_debounce.sv
// key_debounce: one push button -> 2-flop synchroniser, debounce FSM,
// one-cycle press pulse and debounced held level.
// Optional auto-repeat when KEY_AUTOREPEAT_EN is defined.
//   Clk       : system clock
//   Reset     : synchronous, active-high
//   i_key_n   : raw button, active low, asynchronous to Clk
//   o_pressed : one-cycle pulse on accepted press (and on each repeat)
//   o_held    : 1 in PRESSED and DB_RELEASE
module key_debounce
  import key_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  key_state_t       r_state;
  key_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_done;
  logic             w_accept;
  logic             w_repeat;
  logic             r_pulse;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (!r_sync2) w_next = DB_PRESS;
      DB_PRESS:   if (r_sync2) w_next = IDLE;
                  else if (w_cnt_done) w_next = PRESSED;
      PRESSED:    if (r_sync2) w_next = DB_RELEASE;
      DB_RELEASE: if (!r_sync2) w_next = PRESSED;
                  else if (w_cnt_done) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  // Counter only runs while staying in a debounce state; any level change
  // moves the FSM and therefore restarts the count from zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if ((r_state != w_next) || (r_state == IDLE) || (r_state == PRESSED)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_accept = (r_state == DB_PRESS) && (w_next == PRESSED);

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_hold;
  logic             r_phase;  // 0: waiting for first repeat, 1: periodic repeats
  logic [REP_W-1:0] w_target;
  logic             w_stay;

  assign w_target = r_phase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
  // Only cycles that remain in PRESSED advance the hold time; a release
  // bounce freezes it, an accepted release clears it.
  assign w_stay   = (r_state == PRESSED) && !r_sync2;
  assign w_repeat = w_stay && (r_hold == w_target);

  always_ff @(posedge Clk) begin
    if (Reset || (r_state == IDLE) || (r_state == DB_PRESS)) begin
      r_hold  <= '0;
      r_phase <= 1'b0;
    end else if (w_stay) begin
      if (w_repeat) begin
        r_hold  <= '0;
        r_phase <= 1'b1;
      end else begin
        r_hold  <= r_hold + REP_W'(1);
      end
    end
  end
`else
  // Single pulse per press; the repeat timing parameters have no effect.
  assign w_repeat = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) r_pulse <= 1'b0;
    else       r_pulse <= w_accept | w_repeat;
  end

  always_comb begin
    o_pressed = r_pulse;
    o_held    = (r_state == PRESSED) || (r_state == DB_RELEASE);
  end

endmodule

// File: rtl/key_step_counter.sv
// key_step_counter: debounces NUM_KEYS active-low buttons and steps a
// bounded index with key 0 (+1) and key 1 (-1).
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat while held).
//   Clk   : system clock
//   Reset : synchronous, active-high
//   bus   : key_step_counter_if slave (KEY_N in; key_pressed, key_held,
//           index, index_wrap out)
module key_step_counter
  import key_step_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int IDX_W           = 5,
  parameter int MAX_INDEX       = 21,
  parameter int WRAP            = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic          Clk,
  input logic          Reset,
  key_step_counter_if.slave bus
);

  localparam int IDX1 = IDX_W + 1;

  logic [NUM_KEYS-1:0] w_pressed;
  logic [NUM_KEYS-1:0] w_held;
  logic [IDX_W-1:0]    r_index;
  logic                r_wrap;
  logic [IDX_W-1:0]    w_index_nxt;
  logic                w_wrap_nxt;
  logic [IDX1-1:0]     w_up;
  logic [IDX1-1:0]     w_dn;
  logic                w_inc;
  logic                w_dec;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key (
      .Clk       (Clk),
      .Reset     (Reset),
      .i_key_n   (bus.KEY_N[k]),
      .o_pressed (w_pressed[k]),
      .o_held    (w_held[k])
    );
  end

  assign w_inc = w_pressed[INC_KEY];
  assign w_dec = w_pressed[DEC_KEY];

  // One extra bit exposes both overflow past MAX_INDEX and underflow below 0.
  assign w_up = {1'b0, r_index} + IDX1'(1);
  assign w_dn = {1'b0, r_index} - IDX1'(1);

  always_comb begin
    w_index_nxt = r_index;
    w_wrap_nxt  = 1'b0;
    if (w_inc && !w_dec) begin
      if (w_up > IDX1'(MAX_INDEX)) begin
        if (WRAP != 0) begin
          w_index_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        w_index_nxt = w_up[IDX_W-1:0];
      end
    end else if (w_dec && !w_inc) begin
      if (w_dn[IDX_W]) begin
        if (WRAP != 0) begin
          w_index_nxt = IDX_W'(MAX_INDEX);
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        w_index_nxt = w_dn[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_index <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_index <= w_index_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign bus.key_pressed = w_pressed;
  assign bus.key_held    = w_held;
  assign bus.index       = r_index;
  assign bus.index_wrap  = r_wrap;

endmodule
